// File: rtl/piso_tx_if.sv
// Parallel-in serial-out transmitter bus: load handshake toward the
// transmitter and the serial stream, status and captured word coming back.
interface piso_tx_if #(
   parameter int N = 8
);
   logic         l;
   logic [N-1:0] d;
   logic         rdy;
   logic         so;
   logic         sv;
   logic         done;
   logic [N-1:0] q;

   // Producer side: issues load requests and observes the serial stream
   modport master (
      output l,
      output d,
      input  rdy,
      input  so,
      input  sv,
      input  done,
      input  q
   );

   // Transmitter side
   modport slave (
      input  l,
      input  d,
      output rdy,
      output so,
      output sv,
      output done,
      output q
   );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter. A word accepted in IDLE is shifted out
// MSB first over N cycles, followed by a single DONE cycle carrying a done
// pulse. All outputs come straight from registers, so nothing on the load
// side ripples combinationally into the serial side.
module piso_tx #(
   parameter int N = 8
) (
   input  logic      ck,
   input  logic      rst,
   piso_tx_if.slave  bus
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t        state_q;
   logic [N-1:0]  shift_q;
   logic [N-1:0]  shift_d;
   logic [N-1:0]  word_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          rdy_q;
   logic          so_q;
   logic          sv_q;
   logic          done_q;

   // Next values of the shift register (left shift, zero fill) and bit counter
   always_comb begin
      shift_d = {shift_q[N-2:0], 1'b0};
      cnt_d   = cnt_q - 1'b1;
   end

   // Frame sequencer: loads in IDLE, shifts for N cycles, pulses done once;
   // the outputs are registered alongside the state they describe
   always_ff @(posedge ck) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         rdy_q   <= 1'b1;
         so_q    <= 1'b0;
         sv_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.l) begin
                  shift_q <= bus.d;
                  word_q  <= bus.d;
                  cnt_q   <= CW'(N - 1);
                  state_q <= SHIFT;
                  rdy_q   <= 1'b0;
                  sv_q    <= 1'b1;
                  so_q    <= bus.d[N-1];
               end
            end
            SHIFT: begin
               shift_q <= shift_d;
               if (cnt_q == '0) begin
                  state_q <= DONE;
                  sv_q    <= 1'b0;
                  so_q    <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q   <= cnt_d;
                  so_q    <= shift_q[N-2];
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               rdy_q   <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               rdy_q   <= 1'b1;
               so_q    <= 1'b0;
               sv_q    <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rdy  = rdy_q;
   assign bus.so   = so_q;
   assign bus.sv   = sv_q;
   assign bus.done = done_q;
   assign bus.q    = word_q;

endmodule

// File: tb/tb_piso_tx.sv
// Testbench for piso_tx: an 8-bit and a 4-bit instance. Stimulus pushes the
// expected serial bits and done events into per-instance queues; monitors pop
// and compare whenever an instance presents sv or done.
module tb_piso_tx;

   typedef struct packed {
      logic       isDone;
      logic       bitVal;
      logic [7:0] qVal;
   } item_t;

   logic ck;
   logic rst;
   int   checks;
   int   failures;
   item_t sb8[$];
   item_t sb4[$];

   piso_tx_if #(.N(8)) bus8 ();
   piso_tx_if #(.N(4)) bus4 ();

   piso_tx #(.N(8)) dut8 (
      .ck  (ck),
      .rst (rst),
      .bus (bus8.slave)
   );

   piso_tx #(.N(4)) dut4 (
      .ck  (ck),
      .rst (rst),
      .bus (bus4.slave)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      ck = 1'b0;
      forever #5 ck = ~ck;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic applyStimulus(input logic lv, input logic [7:0] dv);
      bus8.l = lv;
      bus8.d = dv;
   endtask

   task automatic pushFrame8(input logic [7:0] word, input int nBits);
      item_t it;
      for (int i = 0; i < nBits; i++) begin
         it.isDone = 1'b0;
         it.bitVal = word[7 - i];
         it.qVal   = word;
         sb8.push_back(it);
      end
   endtask

   task automatic pushDone8(input logic [7:0] word);
      item_t it;
      it.isDone = 1'b1;
      it.bitVal = 1'b0;
      it.qVal   = word;
      sb8.push_back(it);
   endtask

   task automatic checkIdle8(input string tag, input logic [7:0] expQ);
      checkOutput({tag, ".rdy"},  {31'd0, bus8.rdy},  32'd1);
      checkOutput({tag, ".sv"},   {31'd0, bus8.sv},   32'd0);
      checkOutput({tag, ".so"},   {31'd0, bus8.so},   32'd0);
      checkOutput({tag, ".done"}, {31'd0, bus8.done}, 32'd0);
      checkOutput({tag, ".q"},    {24'd0, bus8.q},    {24'd0, expQ});
   endtask

   // Monitor for the 8-bit instance: every sv or done cycle must match the queue head
   always @(negedge ck) begin
      item_t it;
      if (bus8.sv === 1'b1 || bus8.done === 1'b1) begin
         if (sb8.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL mon8.unexpected: sv=%0b done=%0b with nothing expected", bus8.sv, bus8.done);
         end else begin
            it = sb8.pop_front();
            checkOutput("mon8.kind", {31'd0, bus8.done}, {31'd0, it.isDone});
            if (it.isDone) begin
               checkOutput("mon8.q", {24'd0, bus8.q}, {24'd0, it.qVal});
               checkOutput("mon8.svLowInDone", {31'd0, bus8.sv}, 32'd0);
            end else begin
               checkOutput("mon8.so", {31'd0, bus8.so}, {31'd0, it.bitVal});
               checkOutput("mon8.q", {24'd0, bus8.q}, {24'd0, it.qVal});
            end
         end
      end
   end

   // Monitor for the 4-bit instance
   always @(negedge ck) begin
      item_t it;
      if (bus4.sv === 1'b1 || bus4.done === 1'b1) begin
         if (sb4.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL mon4.unexpected: sv=%0b done=%0b with nothing expected", bus4.sv, bus4.done);
         end else begin
            it = sb4.pop_front();
            checkOutput("mon4.kind", {31'd0, bus4.done}, {31'd0, it.isDone});
            if (it.isDone)
               checkOutput("mon4.q", {28'd0, bus4.q}, {24'd0, it.qVal});
            else
               checkOutput("mon4.so", {31'd0, bus4.so}, {31'd0, it.bitVal});
         end
      end
   end

   // Directed scenarios
   initial begin
      item_t it;
      logic [3:0] w4;
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      applyStimulus(1'b0, 8'h00);
      bus4.l   = 1'b0;
      bus4.d   = 4'h0;

      // Reset for two cycles, then idle for five
      tick();
      tick();
      rst = 1'b0;
      checkIdle8("reset", 8'h00);
      checkOutput("reset4.rdy", {31'd0, bus4.rdy}, 32'd1);
      checkOutput("reset4.q", {28'd0, bus4.q}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkIdle8("idle", 8'h00);
      end

      // Single frame 00000011 with an ignored load of 00001111 mid-frame
      applyStimulus(1'b1, 8'h03);
      pushFrame8(8'h03, 8);
      pushDone8(8'h03);
      tick();
      applyStimulus(1'b0, 8'h03);
      checkOutput("frame1.rdyLow", {31'd0, bus8.rdy}, 32'd0);
      checkOutput("frame1.svHigh", {31'd0, bus8.sv}, 32'd1);
      tick();
      tick();
      applyStimulus(1'b1, 8'h0F);
      tick();
      applyStimulus(1'b0, 8'h0F);
      checkOutput("ignored.q", {24'd0, bus8.q}, 32'h03);
      checkOutput("ignored.rdy", {31'd0, bus8.rdy}, 32'd0);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("frame1.doneCycle9", {31'd0, bus8.done}, 32'd1);
      tick();
      checkIdle8("frame1.cycle10", 8'h03);

      // Back-to-back frames with l held high
      applyStimulus(1'b1, 8'hAA);
      pushFrame8(8'hAA, 8);
      pushDone8(8'hAA);
      pushFrame8(8'h0F, 8);
      pushDone8(8'h0F);
      tick();
      applyStimulus(1'b1, 8'h0F);
      for (int i = 0; i < 8; i++) tick();
      checkOutput("b2b.doneCycle9", {31'd0, bus8.done}, 32'd1);
      tick();
      checkOutput("b2b.idleCycle10", {31'd0, bus8.rdy}, 32'd1);
      checkOutput("b2b.svLowCycle10", {31'd0, bus8.sv}, 32'd0);
      tick();
      applyStimulus(1'b0, 8'h0F);
      checkOutput("b2b.svCycle11", {31'd0, bus8.sv}, 32'd1);
      checkOutput("b2b.qCycle11", {24'd0, bus8.q}, 32'h0F);
      for (int i = 0; i < 8; i++) tick();
      checkOutput("b2b.doneCycle19", {31'd0, bus8.done}, 32'd1);
      tick();
      checkIdle8("b2b.cycle20", 8'h0F);

      // Mid-frame reset after the third bit of 11110000
      applyStimulus(1'b1, 8'hF0);
      pushFrame8(8'hF0, 3);
      tick();
      applyStimulus(1'b0, 8'hF0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkIdle8("abort", 8'h00);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("abort.noDone", {31'd0, bus8.done}, 32'd0);
      end

      // Reset wins over a simultaneous load
      rst = 1'b1;
      applyStimulus(1'b1, 8'hFF);
      tick();
      rst = 1'b0;
      applyStimulus(1'b0, 8'hFF);
      checkIdle8("rstPriority", 8'h00);
      tick();
      checkOutput("rstPriority.noFrame", {31'd0, bus8.sv}, 32'd0);

      // Four-bit instance, word 1001
      w4 = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         it.isDone = 1'b0;
         it.bitVal = w4[3 - i];
         it.qVal   = 8'h09;
         sb4.push_back(it);
      end
      it.isDone = 1'b1;
      it.bitVal = 1'b0;
      it.qVal   = 8'h09;
      sb4.push_back(it);
      bus4.l = 1'b1;
      bus4.d = w4;
      tick();
      bus4.l = 1'b0;
      checkOutput("n4.firstBit", {31'd0, bus4.so}, 32'd1);
      for (int i = 0; i < 4; i++) tick();
      checkOutput("n4.doneCycle5", {31'd0, bus4.done}, 32'd1);
      tick();
      checkOutput("n4.rdyCycle6", {31'd0, bus4.rdy}, 32'd1);
      checkOutput("n4.q", {28'd0, bus4.q}, 32'h9);

      // Every expected event must have been observed
      tick();
      tick();
      checkOutput("sb8.drained", sb8.size(), 32'd0);
      checkOutput("sb4.drained", sb4.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
